// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PIPE width/lane types and helpers for the TX striper
package pcie_phy_pkg;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2
    } pipe_width_e;

    localparam int DWORD_BYTES = 4;

    // Bytes carried by one full LPIF beat of ndword dwords.
    function automatic int beat_bytes(input int ndword);
        return ndword * DWORD_BYTES;
    endfunction

    // Encodings 2 and 3 both select the 32-bit PIPE width.
    function automatic pipe_width_e width_decode(input logic [1:0] w);
        case (w)
            2'd0:    return W8;
            2'd1:    return W16;
            default: return W32;
        endcase
    endfunction

    function automatic logic [2:0] width_bytes(input pipe_width_e w);
        case (w)
            W8:      return 3'd1;
            W16:     return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Anything other than a supported power-of-two link width falls back to x1.
    function automatic logic [4:0] lanes_decode(input logic [4:0] n, input int max_lanes);
        logic [4:0] r;
        r = 5'd1;
        case (n)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: if (int'(n) <= max_lanes) r = n;
            default: r = 5'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcie_byte_fifo.sv
// rtl/pcie_byte_fifo.sv - circular byte store with variable-count write and read ports
module pcie_byte_fifo #(
    parameter int CAP    = 256,
    parameter int WR_MAX = 64,
    parameter int RD_MAX = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(WR_MAX+1)-1:0]   wr_cnt,
    input  logic [WR_MAX*8-1:0]           wr_data,
    input  logic [$clog2(RD_MAX+1)-1:0]   rd_cnt,
    output logic [RD_MAX*8-1:0]           rd_data,
    output logic [$clog2(CAP+1)-1:0]      count
);

    localparam int PW = $clog2(CAP);
    localparam int CW = $clog2(CAP+1);

    logic [7:0]    mem [CAP];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointer advance modulo CAP; CAP need not be a power of two, and both
    // operands stay below CAP so a single subtraction is enough.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = {{(32-PW){1'b0}}, base} + off;
        if (s >= CAP) s = s - CAP;
        return s[PW-1:0];
    endfunction

    // Store the accepted bytes starting at the write pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_MAX; i++) begin
            if (i < int'(wr_cnt)) mem[wrap_add(wr_ptr, i)] <= wr_data[i*8 +: 8];
        end
    end

    // Pointers and occupancy; simultaneous push and pop are both applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wrap_add(wr_ptr, 32'(wr_cnt));
            rd_ptr <= wrap_add(rd_ptr, 32'(rd_cnt));
            count  <= count + CW'(wr_cnt) - CW'(rd_cnt);
        end
    end

    // Present the next RD_MAX bytes from the read pointer, spanning the wrap.
    always_comb begin
        for (int i = 0; i < RD_MAX; i++) rd_data[i*8 +: 8] = mem[wrap_add(rd_ptr, i)];
    end

endmodule

// File: rtl/pcie_tx_lane_striper.sv
// rtl/pcie_tx_lane_striper.sv - LPIF to PIPE transmit byte striper across active lanes
module pcie_tx_lane_striper
    import pcie_phy_pkg::*;
#(
    parameter int NDWORD       = 16,
    parameter int MAXPIPEWIDTH = 32,
    parameter int LANESNUMBER  = 16,
    parameter int DEPTH        = 4
) (
    input  logic                                CLK,
    input  logic                                reset,
    input  logic [1:0]                          width,
    input  logic [4:0]                          num_lanes,
    input  logic                                lp_irdy,
    input  logic [NDWORD-1:0]                   lp_valid,
    input  logic [NDWORD*32-1:0]                lp_data,
    input  logic                                tx_flush,
    output logic                                pl_trdy,
    output logic [LANESNUMBER*MAXPIPEWIDTH-1:0] TxData,
    output logic                                TxDataValid,
    output logic                                tx_empty
);

    localparam int BEAT   = beat_bytes(NDWORD);
    localparam int CAP    = DEPTH * BEAT;
    localparam int SLOTS  = MAXPIPEWIDTH / 8;
    localparam int RD_MAX = LANESNUMBER * SLOTS;
    localparam int CW     = $clog2(CAP+1);
    localparam int WCW    = $clog2(BEAT+1);
    localparam int RCW    = $clog2(RD_MAX+1);

    logic [CW-1:0]                          count;
    logic [RD_MAX*8-1:0]                    rd_data;
    logic                                   push;
    logic [WCW-1:0]                         push_bytes;
    logic [RCW-1:0]                         pop_cnt;
    logic [2:0]                             wb;
    int                                     grp_i;
    int                                     cnt_next_i;
    pipe_width_e                            width_q;
    logic [4:0]                             lanes_q;
    logic                                   flush_q;
    logic [LANESNUMBER*MAXPIPEWIDTH-1:0]    xbar;

    assign pl_trdy  = !reset && ((CW'(CAP) - count) >= CW'(BEAT));
    assign tx_empty = (count == '0) && !flush_q;

    pcie_byte_fifo #(
        .CAP    (CAP),
        .WR_MAX (BEAT),
        .RD_MAX (RD_MAX)
    ) u_fifo (
        .clk     (CLK),
        .reset   (reset),
        .wr_cnt  (push_bytes),
        .wr_data (lp_data),
        .rd_cnt  (pop_cnt),
        .rd_data (rd_data),
        .count   (count)
    );

    // Push size, group size and pop decision (full group, or padded tail under flush).
    always_comb begin
        push       = lp_irdy && pl_trdy;
        push_bytes = '0;
        if (push) begin
            for (int d = 0; d < NDWORD; d++) begin
                if (lp_valid[d]) push_bytes = push_bytes + WCW'(DWORD_BYTES);
            end
        end
        wb = width_bytes(width_q);
        if (int'(wb) > SLOTS) wb = 3'(SLOTS);
        grp_i   = int'(lanes_q) * int'(wb);
        pop_cnt = '0;
        if (int'(count) >= grp_i) pop_cnt = RCW'(grp_i);
        else if (flush_q && count != '0) pop_cnt = RCW'(count);
        cnt_next_i = int'(count) + int'(push_bytes) - int'(pop_cnt);
    end

    // Link configuration only changes while the FIFO is idle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            width_q <= W8;
            lanes_q <= 5'd1;
        end else if (count == '0 && !push) begin
            width_q <= width_decode(width);
            lanes_q <= lanes_decode(num_lanes, LANESNUMBER);
        end
    end

    // Flush stays pending until the buffered tail has fully drained.
    always_ff @(posedge CLK) begin
        if (reset) flush_q <= 1'b0;
        else       flush_q <= (flush_q || tx_flush) && (cnt_next_i != 0);
    end

    // Byte i of the popped group lands on lane i mod lanes, slot i div lanes.
    always_comb begin
        int idx;
        idx  = 0;
        xbar = '0;
        for (int l = 0; l < LANESNUMBER; l++) begin
            for (int s = 0; s < SLOTS; s++) begin
                idx = s * int'(lanes_q) + l;
                if (l < int'(lanes_q) && s < int'(wb) && idx < int'(pop_cnt))
                    xbar[l*MAXPIPEWIDTH + s*8 +: 8] = rd_data[idx*8 +: 8];
            end
        end
    end

    // Registered PIPE outputs; idle cycles drive zero data.
    always_ff @(posedge CLK) begin
        if (reset) begin
            TxData      <= '0;
            TxDataValid <= 1'b0;
        end else begin
            TxData      <= xbar;
            TxDataValid <= (pop_cnt != '0);
        end
    end

endmodule
